oclib_csr_arbiter: RTL and testbench

OCLIB_CSR_ARBITER -- requirements
Module: oclib_csr_arbiter

---
 rtl/oclib_csr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_oclib_csr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oclib_csr_arbiter.sv
// oclib_csr_arbiter
//   Round-robin arbiter that funnels NumIn upstream CSR requesters onto one
//   downstream CSR bus. One transaction is in flight at a time. The grant
//   is registered, the downstream request is latched, and the reply is
//   returned to the winning requester for exactly one cycle.
//
// Ports
//   clock  : sole clock
//   reset  : synchronous active-high reset
//   in     : upstream requests, one per requester (held until ready)
//   inFb   : upstream feedback; ready pulses one cycle for the winner only
//   out    : registered downstream request
//   outFb  : downstream feedback (ready / error / rdata)
//   grant  : one-hot owner of the downstream bus (bit i <-> in[i]), zero when idle

package oclib_pkg;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [31:0] wdata;
    } csr_32_s;

    typedef struct packed {
        logic        ready;
        logic        error;
        logic [31:0] rdata;
    } csr_32_fb_s;

endpackage

module oclib_csr_arbiter #(
    parameter int  NumIn         = 2,
    parameter int  TimeoutCycles = 256,
    parameter type CsrType       = oclib_pkg::csr_32_s,
    parameter type CsrFbType     = oclib_pkg::csr_32_fb_s
) (
    input  logic             clock,
    input  logic             reset,
    input  CsrType           in    [0:NumIn-1],
    output CsrFbType         inFb  [0:NumIn-1],
    output CsrType           out,
    input  CsrFbType         outFb,
    output logic [0:NumIn-1] grant
);

    localparam int          PtrW    = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int          CntW    = $clog2(TimeoutCycles) + 1;
    localparam int unsigned NumInU  = NumIn;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(NumIn - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_e;

    state_e            state_q,  state_d;
    logic [PtrW-1:0]   ptr_q,    ptr_d;
    logic [PtrW-1:0]   winner_q, winner_d;
    logic [CntW-1:0]   count_q,  count_d;
    CsrType            out_q,    out_d;
    logic [0:NumIn-1]  grant_q,  grant_d;
    CsrFbType          in_fb_q   [0:NumIn-1];
    CsrFbType          in_fb_d   [0:NumIn-1];

    logic [NumIn-1:0]  active;
    logic              pick_found;
    logic [PtrW-1:0]   pick_idx;
    int unsigned       scan_idx;
    CsrFbType          fb_d;

    // ------------------------------------------------------------------
    // Requester activity and round-robin pick starting at ptr_q
    // ------------------------------------------------------------------
    always_comb begin
        active = '0;
        for (int unsigned i = 0; i < NumInU; i++) begin
            active[i] = in[i].read | in[i].write;
        end
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int unsigned k = 0; k < NumInU; k++) begin
            // Wrap by subtraction: ptr_q < NumIn and k < NumIn, so one step suffices.
            scan_idx = 32'(ptr_q) + k;
            if (scan_idx >= NumInU) begin
                scan_idx = scan_idx - NumInU;
            end
            if (!pick_found && active[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = PtrW'(scan_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic for the FSM and all registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        count_d  = count_q;
        out_d    = out_q;
        grant_d  = grant_q;
        in_fb_d  = in_fb_q;
        fb_d     = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    out_d          = '0;
                    out_d.read     = in[pick_idx].read;
                    out_d.write    = in[pick_idx].write;
                    out_d.address  = in[pick_idx].address;
                    out_d.wdata    = in[pick_idx].wdata;
                    grant_d        = '0;
                    grant_d[pick_idx] = 1'b1;
                    winner_d       = pick_idx;
                    count_d        = '0;
                    state_d        = ISSUE;
                end
            end

            ISSUE: begin
                // Ready is checked before expiry so a reply on the last
                // allowed cycle completes normally.
                if (outFb.ready) begin
                    out_d.read          = 1'b0;
                    out_d.write         = 1'b0;
                    fb_d.ready          = 1'b1;
                    fb_d.error          = outFb.error;
                    fb_d.rdata          = outFb.rdata;
                    in_fb_d[winner_q]   = fb_d;
                    state_d             = DONE;
                end else if (count_q == CntLast) begin
                    out_d               = '0;
                    fb_d.ready          = 1'b1;
                    fb_d.error          = 1'b1;
                    in_fb_d[winner_q]   = fb_d;
                    state_d             = DONE;
                end else if (count_q != '1) begin
                    count_d = count_q + CntW'(1);
                end
            end

            DONE: begin
                for (int unsigned i = 0; i < NumInU; i++) begin
                    in_fb_d[i] = '0;
                end
                grant_d = '0;
                ptr_d   = (winner_q == PtrLast) ? '0 : winner_q + PtrW'(1);
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            grant_q  <= '0;
            for (int unsigned i = 0; i < NumInU; i++) begin
                in_fb_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            count_q  <= count_d;
            out_q    <= out_d;
            grant_q  <= grant_d;
            in_fb_q  <= in_fb_d;
        end
    end

    assign out   = out_q;
    assign grant = grant_q;
    assign inFb  = in_fb_q;

endmodule

// File: tb/tb_oclib_csr_arbiter.sv
// Bench for oclib_csr_arbiter (NumIn=2, TimeoutCycles=8).
// A transaction-level model predicts grant, the downstream request and the
// upstream replies every cycle; directed scenarios add literal expectations.
module tb_oclib_csr_arbiter;
    import oclib_pkg::*;

    localparam int N  = 2;
    localparam int TO = 8;

    logic         clock = 1'b0;
    logic         reset;
    csr_32_s      in_r  [0:N-1];
    csr_32_fb_s   in_fb [0:N-1];
    csr_32_s      out_r;
    csr_32_fb_s   out_fb;
    logic [0:N-1] grant;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    oclib_csr_arbiter #(
        .NumIn         (N),
        .TimeoutCycles (TO),
        .CsrType       (csr_32_s),
        .CsrFbType     (csr_32_fb_s)
    ) dut (
        .clock (clock),
        .reset (reset),
        .in    (in_r),
        .inFb  (in_fb),
        .out   (out_r),
        .outFb (out_fb),
        .grant (grant)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the bus, how long the request has been out,
    // and whether this cycle is the reply cycle.
    // ------------------------------------------------------------------
    bit          m_valid = 0;
    int          m_owner = -1;
    int          m_ptr   = 0;
    int          m_age   = 0;
    bit          m_out   = 0;
    bit          m_reply = 0;
    bit          m_rd, m_wr;
    logic [31:0] m_addr, m_wdata;
    bit          m_rep_err;
    logic [31:0] m_rep_data;

    always @(posedge clock) begin
        if (reset) begin
            m_valid = 1; m_owner = -1; m_ptr = 0; m_out = 0; m_reply = 0;
            m_rd = 0; m_wr = 0;
        end else if (m_reply) begin
            m_reply = 0;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (m_out) begin
            if (out_fb.ready) begin
                m_reply = 1; m_rep_err = out_fb.error; m_rep_data = out_fb.rdata;
                m_out = 0; m_rd = 0; m_wr = 0;
            end else if (m_age == TO - 1) begin
                m_reply = 1; m_rep_err = 1; m_rep_data = 0;
                m_out = 0; m_rd = 0; m_wr = 0;
            end else begin
                m_age++;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && (in_r[idx].read || in_r[idx].write)) begin
                    m_owner = idx; m_out = 1; m_age = 0;
                    m_rd = in_r[idx].read; m_wr = in_r[idx].write;
                    m_addr = in_r[idx].address; m_wdata = in_r[idx].wdata;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            logic [0:N-1] g;
            logic [63:0]  f;
            g = '0;
            if (m_owner >= 0) g[m_owner] = 1'b1;
            chk("grant", 64'(grant), 64'(g));
            chk("out_rw", {62'd0, out_r.read, out_r.write}, {62'd0, m_rd, m_wr});
            if (m_rd || m_wr)
                chk("out_addr_wdata", {out_r.address, out_r.wdata}, {m_addr, m_wdata});
            for (int i = 0; i < N; i++) begin
                f = '0;
                if (m_reply && m_owner == i) f = {30'd0, 1'b1, m_rep_err, m_rep_data};
                chk($sformatf("inFb%0d", i), 64'(in_fb[i]), f);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: requesters and a reactive target
    // ------------------------------------------------------------------
    int          act_cyc = 0;
    int          tgt_delay_cur = 0;
    int          tgt_delay_cfg = -1;   // -1: random per transaction
    logic [31:0] tgt_rdata = '0;
    logic        tgt_err = 1'b0;
    int          tgt_writes = 0;
    bit          reissue [0:N-1];
    int          done_q [$];
    int          n_done = 0;

    task automatic step();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (in_fb[i].ready) begin
                done_q.push_back(i);
                n_done++;
                if (reissue[i]) in_r[i].wdata = in_r[i].wdata + 32'd1;
                else            in_r[i] = '0;
            end
        end
        out_fb.ready = 1'b0;
        out_fb.error = 1'($urandom_range(0, 1));
        out_fb.rdata = $urandom;
        if (out_r.read || out_r.write) begin
            if (act_cyc == 0)
                tgt_delay_cur = (tgt_delay_cfg < 0) ? int'($urandom_range(0, 9)) : tgt_delay_cfg;
            if (act_cyc >= tgt_delay_cur) begin
                out_fb.ready = 1'b1;
                out_fb.error = (tgt_delay_cfg < 0) ? ($urandom_range(0, 3) == 0) : tgt_err;
                out_fb.rdata = (tgt_delay_cfg < 0) ? $urandom : tgt_rdata;
                if (out_r.write) tgt_writes++;
            end
            act_cyc++;
        end else begin
            act_cyc = 0;
        end
    endtask

    task automatic issue(input int i, input bit rd, input logic [31:0] addr, input logic [31:0] wd);
        in_r[i].read    = rd;
        in_r[i].write   = !rd;
        in_r[i].address = addr;
        in_r[i].wdata   = wd;
    endtask

    task automatic wait_fb(input int i, input int budget, output bit ok, output int n,
                           output logic err, output logic [31:0] data);
        ok = 0; n = 0; err = 'x; data = 'x;
        while (!ok && n < budget) begin
            step();
            n++;
            if (in_fb[i].ready) begin
                ok = 1; err = in_fb[i].error; data = in_fb[i].rdata;
            end
        end
    endtask

    task automatic count_active(output int cnt);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!(out_r.read || out_r.write)) break;
            cnt++;
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          n;
        logic        e;
        logic [31:0] d;

        reset = 1'b1;
        for (int i = 0; i < N; i++) begin in_r[i] = '0; reissue[i] = 0; end
        out_fb = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_out", 64'(out_r), 64'd0);
        chk("reset_fb0", 64'(in_fb[0]), 64'd0);

        // Single read, target replies one cycle after seeing out.read
        tgt_delay_cfg = 1; tgt_rdata = 32'hCAFE0001; tgt_err = 0;
        issue(0, 1, 32'h10, 32'h0);
        step();
        chk("t27_grant", 64'(grant), 64'(2'b10));
        chk("t27_read", 64'(out_r.read), 64'd1);
        chk("t27_addr", 64'(out_r.address), 64'h10);
        wait_fb(0, 20, ok, n, e, d);
        chk("t27_done", 64'(ok), 64'd1);
        chk("t27_latency", 64'(n), 64'd2);
        chk("t27_rdata", 64'(d), 64'hCAFE0001);
        chk("t27_error", 64'(e), 64'd0);
        repeat (3) step();

        // Both requesters write continuously from reset
        reset = 1'b1;
        issue(0, 0, 32'h100, 32'hA000); issue(1, 0, 32'h200, 32'hB000);
        reissue[0] = 1; reissue[1] = 1;
        tgt_delay_cfg = 0;
        repeat (2) step();
        reset = 1'b0;
        done_q.delete(); tgt_writes = 0;
        for (int k = 0; k < 60 && done_q.size() < 4; k++) step();
        chk("t28_count", 64'(done_q.size()), 64'd4);
        if (done_q.size() >= 4) begin
            chk("t28_order", {done_q[0][15:0], done_q[1][15:0], done_q[2][15:0], done_q[3][15:0]},
                64'h0000_0001_0000_0001);
        end
        chk("t28_writes", 64'(tgt_writes), 64'd4);
        reissue[0] = 0; reissue[1] = 0;
        in_r[0] = '0; in_r[1] = '0;
        repeat (12) step();

        // Target never answers -> timeout after TO cycles
        tgt_delay_cfg = 1000;
        issue(0, 1, 32'h20, 32'h0);
        step();
        count_active(n);
        chk("t29_active", 64'(n), 64'd8);
        chk("t29_fb", 64'(in_fb[0]), {30'd0, 1'b1, 1'b1, 32'h0});
        repeat (3) step();

        // Reply on the very last allowed cycle wins
        tgt_delay_cfg = 7; tgt_rdata = 32'h5; tgt_err = 0;
        issue(1, 1, 32'h30, 32'h0);
        step();
        count_active(n);
        chk("t30_active", 64'(n), 64'd8);
        chk("t30_fb", 64'(in_fb[1]), {30'd0, 1'b1, 1'b0, 32'h5});
        repeat (3) step();

        // Reset while a transaction is outstanding
        tgt_delay_cfg = 1000;
        issue(0, 0, 32'h50, 32'h1);
        repeat (2) step();
        chk("t31_grant_pre", 64'(grant), 64'(2'b10));
        reset = 1'b1;
        in_r[0] = '0;
        issue(1, 1, 32'h60, 32'h0);
        step();
        chk("t31_out", 64'({out_r.read, out_r.write}), 64'd0);
        chk("t31_grant", 64'(grant), 64'd0);
        chk("t31_ready", 64'({in_fb[0].ready, in_fb[1].ready}), 64'd0);
        reset = 1'b0;
        step();
        chk("t31_grant_post", 64'(grant), 64'(2'b01));
        chk("t31_addr", 64'(out_r.address), 64'h60);
        tgt_delay_cur = 0; tgt_rdata = 32'h99;
        wait_fb(1, 20, ok, n, e, d);
        chk("t31_done", {31'd0, ok, e, d}, {31'd0, 1'b1, 1'b0, 32'h99});
        repeat (3) step();

        // Target error on a write, next requester serviced normally
        tgt_delay_cfg = 1; tgt_err = 1; tgt_rdata = 32'h0;
        issue(0, 0, 32'h40, 32'h1234);
        wait_fb(0, 20, ok, n, e, d);
        chk("t32_err", {62'd0, ok, e}, {62'd0, 1'b1, 1'b1});
        tgt_err = 0; tgt_rdata = 32'h77;
        issue(1, 1, 32'h44, 32'h0);
        wait_fb(1, 20, ok, n, e, d);
        chk("t32_next", {31'd0, ok, e, d}, {31'd0, 1'b1, 1'b0, 32'h77});
        repeat (3) step();

        // Randomised traffic with occasional drops and resets
        tgt_delay_cfg = -1;
        n_done = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N; i++) begin
                if (!(in_r[i].read || in_r[i].write)) begin
                    if ($urandom_range(0, 3) == 0)
                        issue(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end else if ($urandom_range(0, 49) == 0) begin
                    in_r[i] = '0;
                end
            end
            step();
        end
        reset = 1'b0;
        in_r[0] = '0; in_r[1] = '0;
        repeat (20) step();
        chk("rand_progress", 64'(n_done > 100), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
